// File: rtl/input_arbiter.sv
// input_arbiter: per-input packet FIFOs with round-robin selection feeding the XY routing stage.
// Optional macro ARB_PRIORITY_LOCAL_EN gives input 0 (local) strict priority over the mesh inputs.
module input_arbiter #(
    parameter int PL         = 8,
    parameter int REN        = 5,
    parameter int CS         = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [0:REN-1][0:PL-1] in_packets,
    output logic [0:REN-1]         in_ready,
    input  logic                   stall,
    output logic [0:PL-1]          from_arbiter,
    output logic [$clog2(REN)-1:0] grant_id
);

    localparam int GW = $clog2(REN);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [GW-1:0] LAST_IDX = GW'(REN - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("input_arbiter: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (PL < (1 + 2 * CS)) begin : g_bad_pl
        $error("input_arbiter: PL too small for valid bit plus two coordinates");
    end

    logic [0:PL-1]   mem_r    [0:REN-1][0:FIFO_DEPTH-1];
    logic [AW-1:0]   wr_ptr_r [0:REN-1];
    logic [AW-1:0]   rd_ptr_r [0:REN-1];
    logic [CW-1:0]   count_r  [0:REN-1];
    logic [GW-1:0]   rr_ptr_r;
    logic [0:PL-1]   from_arbiter_r;
    logic [GW-1:0]   grant_id_r;

    logic [0:REN-1]  full_s;
    logic [0:REN-1]  empty_s;
    logic [0:REN-1]  push_s;
    logic [0:REN-1]  pop_s;
    logic            grant_valid_s;
    logic            local_grant_s;
    logic            hit_s;
    logic [GW-1:0]   grant_s;
    logic [GW-1:0]   cand_s;
    logic [0:PL-1]   head_s;

    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] idx);
        logic [GW-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = '0;
        end else begin
            nxt = idx + GW'(1);
        end
        return nxt;
    endfunction

    // FIFO status and push qualification, all from registered counts
    always_comb begin
        full_s  = '0;
        empty_s = '0;
        push_s  = '0;
        for (int i = 0; i < REN; i++) begin
            full_s[i]  = (count_r[i] == FULL_CNT);
            empty_s[i] = (count_r[i] == '0);
            // A full FIFO refuses the word even if it is popped this cycle.
            push_s[i]  = in_packets[i][0] && !full_s[i];
        end
    end

    assign in_ready = ~full_s;

    // Round-robin search starting at rr_ptr; optional local-port override
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = rr_ptr_r;
        local_grant_s = 1'b0;
        cand_s        = rr_ptr_r;
        hit_s         = 1'b0;
        for (int k = 0; k < REN; k++) begin
            hit_s         = !grant_valid_s && !empty_s[cand_s];
            grant_s       = hit_s ? cand_s : grant_s;
            grant_valid_s = grant_valid_s | hit_s;
            cand_s        = wrap_inc(cand_s);
        end
`ifdef ARB_PRIORITY_LOCAL_EN
        if (!empty_s[0]) begin
            grant_valid_s = 1'b1;
            grant_s       = '0;
            local_grant_s = 1'b1;
        end else begin
            local_grant_s = 1'b0;
        end
`endif
    end

    // Head of the granted FIFO and one-hot pop decode
    always_comb begin
        head_s = mem_r[grant_s][rd_ptr_r[grant_s]];
        pop_s  = '0;
        for (int i = 0; i < REN; i++) begin
            pop_s[i] = grant_valid_s && !stall && (grant_s == GW'(i));
        end
    end

    // FIFO storage; contents need no reset because counts gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < REN; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= in_packets[i];
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REN; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < REN; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
                end else begin
                    wr_ptr_r[i] <= wr_ptr_r[i];
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
                end else begin
                    rd_ptr_r[i] <= rd_ptr_r[i];
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CW'(1);
                    2'b01:   count_r[i] <= count_r[i] - CW'(1);
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Output register, grant id and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            from_arbiter_r <= '0;
            grant_id_r     <= '0;
            rr_ptr_r       <= '0;
        end else if (!stall) begin
            if (grant_valid_s) begin
                from_arbiter_r <= head_s;
                grant_id_r     <= grant_s;
                // Local-priority grants leave the mesh rotation where it was.
                if (!local_grant_s) begin
                    rr_ptr_r <= wrap_inc(grant_s);
                end else begin
                    rr_ptr_r <= rr_ptr_r;
                end
            end else begin
                from_arbiter_r <= '0;
                grant_id_r     <= grant_id_r;
                rr_ptr_r       <= rr_ptr_r;
            end
        end else begin
            from_arbiter_r <= from_arbiter_r;
            grant_id_r     <= grant_id_r;
            rr_ptr_r       <= rr_ptr_r;
        end
    end

    assign from_arbiter = from_arbiter_r;
    assign grant_id     = grant_id_r;

endmodule

// File: tb/tb_input_arbiter.sv
// Testbench for input_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based model. Honours ARB_PRIORITY_LOCAL_EN.
module tb_input_arbiter;

    localparam int PL  = 8;
    localparam int REN = 5;
    localparam int CS  = 2;
    localparam int FD  = 4;
    localparam int GW  = $clog2(REN);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [0:REN-1][0:PL-1] in_packets;
    logic [0:REN-1]         in_ready;
    logic                   stall;
    logic [0:PL-1]          from_arbiter;
    logic [GW-1:0]          grant_id;

    input_arbiter #(.PL(PL), .REN(REN), .CS(CS), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_packets   (in_packets),
        .in_ready     (in_ready),
        .stall        (stall),
        .from_arbiter (from_arbiter),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per input, round-robin pointer, output register.
    logic [0:PL-1] mq [REN][$];
    int            m_rr;
    logic [0:PL-1] m_out;
    int            m_gid;

    typedef struct {
        logic [0:REN-1][0:PL-1] pk;
        logic                   st;
        logic [0:PL-1]          out;
        logic [GW-1:0]          gid;
        logic [0:REN-1]         rdy;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [0:REN-1][0:PL-1] pk5(input logic [0:PL-1] a, b, c, d, e);
        logic [0:REN-1][0:PL-1] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
        return r;
    endfunction

    function automatic logic [0:REN-1] model_ready();
        logic [0:REN-1] r;
        for (int i = 0; i < REN; i++) r[i] = (mq[i].size() < FD);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < REN; i++) mq[i].delete();
        m_rr  = 0;
        m_out = '0;
        m_gid = 0;
    endfunction

    function automatic void model_edge(input logic [0:REN-1][0:PL-1] pk, input logic st);
        logic [0:REN-1] rdy;
        bit found;
        int g;
        rdy   = model_ready();
        found = 1'b0;
        g     = 0;
`ifdef ARB_PRIORITY_LOCAL_EN
        if (mq[0].size() > 0) begin found = 1'b1; g = 0; end
`endif
        for (int k = 0; k < REN; k++) begin
            if (!found && mq[(m_rr + k) % REN].size() > 0) begin
                found = 1'b1;
                g = (m_rr + k) % REN;
            end
        end
        if (!st) begin
            if (found) begin
                m_out = mq[g].pop_front();
                m_gid = g;
`ifdef ARB_PRIORITY_LOCAL_EN
                if (g != 0) m_rr = (g + 1) % REN;
`else
                m_rr = (g + 1) % REN;
`endif
            end else begin
                m_out = '0;
            end
        end
        for (int i = 0; i < REN; i++)
            if (pk[i][0] && rdy[i]) mq[i].push_back(pk[i]);
    endfunction

    task automatic cycle(input logic [0:REN-1][0:PL-1] pk, input logic st);
        @(negedge clk);
        in_packets = pk;
        stall      = st;
        @(posedge clk);
        model_edge(pk, st);
        #1;
        check("model_out",   32'(from_arbiter), 32'(m_out));
        check("model_gid",   32'(grant_id),     32'(m_gid));
        check("model_ready", 32'(in_ready),     32'(model_ready()));
    endtask

    function automatic void add(input logic [0:PL-1] a, b, c, d, e, input logic st,
                                input logic [0:PL-1] o, input int g, input logic [0:REN-1] r);
        vec_t v;
        v.pk = pk5(a, b, c, d, e); v.st = st; v.out = o; v.gid = GW'(g); v.rdy = r;
        tbl.push_back(v);
    endfunction

    logic [0:REN-1][0:PL-1] rpk;
    int rate;

    initial begin
        rst_n      = 1'b1;
        stall      = 1'b0;
        in_packets = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_ready", 32'(in_ready),     32'h1F);
        check("reset_out",   32'(from_arbiter), 32'h00);
        check("reset_gid",   32'(grant_id),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef ARB_PRIORITY_LOCAL_EN
        // round robin from rr=0, then from rr=2
        add(8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 1'b0, 8'h00, 0, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h80, 0, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h81, 1, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h82, 2, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h83, 3, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h84, 4, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4, 5'h1F);
        add(8'h00, 8'hA1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA1, 1, 5'h1F);
        add(8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 1'b0, 8'h00, 1, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h8A, 2, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h8B, 3, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h8C, 4, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h88, 0, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h89, 1, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1, 5'h1F);
        // single packet latency
        add(8'h00, 8'h00, 8'h00, 8'hB5, 8'h00, 1'b0, 8'h00, 1, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'hB5, 3, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 3, 5'h1F);
        // stall hold with other FIFOs pending
        add(8'h00, 8'h00, 8'h00, 8'hB5, 8'h00, 1'b0, 8'h00, 3, 5'h1F);
        add(8'h90, 8'h00, 8'h92, 8'h00, 8'h00, 1'b0, 8'hB5, 3, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hB5, 3, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hB5, 3, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hB5, 3, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h90, 0, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h92, 2, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2, 5'h1F);
        // full FIFO on port 1, fifth push dropped
        add(8'h00, 8'hC1, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 2, 5'h1F);
        add(8'h00, 8'hC2, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 2, 5'h1F);
        add(8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 2, 5'h1F);
        add(8'h00, 8'hC4, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 2, 5'b10111);
        add(8'h00, 8'hC5, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 2, 5'b10111);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'hC1, 1, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'hC2, 1, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'hC3, 1, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'hC4, 1, 5'h1F);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1, 5'h1F);
        for (int j = 0; j < tbl.size(); j++) begin
            cycle(tbl[j].pk, tbl[j].st);
            check($sformatf("tbl%0d_out", j),   32'(from_arbiter), 32'(tbl[j].out));
            check($sformatf("tbl%0d_gid", j),   32'(grant_id),     32'(tbl[j].gid));
            check($sformatf("tbl%0d_ready", j), 32'(in_ready),     32'(tbl[j].rdy));
        end
`else
        // local port kept fed while ports 1 and 4 wait
        cycle(pk5(8'hB0, 8'hA1, 8'h00, 8'h00, 8'hA4), 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cycle(pk5(8'hB0 + 8'(k), 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
            check("prio_gid", 32'(grant_id), 32'h0);
            check("prio_out", 32'(from_arbiter), 32'h0B0 + 32'(k) - 32'd1);
        end
        cycle(pk5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
        check("prio_last_local", 32'(from_arbiter), 32'hB4);
        cycle(pk5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
        check("prio_then1_gid", 32'(grant_id), 32'h1);
        check("prio_then1_out", 32'(from_arbiter), 32'hA1);
        cycle(pk5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
        check("prio_then4_gid", 32'(grant_id), 32'h4);
        check("prio_then4_out", 32'(from_arbiter), 32'hA4);
        cycle(pk5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
        check("prio_idle_out", 32'(from_arbiter), 32'h00);
`endif

        // reset in the middle of traffic with buffered packets
        cycle(pk5(8'h00, 8'h00, 8'h00, 8'hB5, 8'h00), 1'b0);
        cycle(pk5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
        check("rst_pre_out", 32'(from_arbiter), 32'hB5);
        for (int k = 0; k < 4; k++)
            cycle(pk5(8'h00, 8'hD1 + 8'(k), (k < 3) ? 8'hE1 + 8'(k) : 8'h00, 8'h00, 8'h00), 1'b1);
        check("rst_pre_ready", 32'(in_ready), 32'(5'b10111));
        @(negedge clk);
        in_packets = '0;
        stall      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(in_ready),     32'h1F);
        check("rst_mid_out",   32'(from_arbiter), 32'h00);
        check("rst_mid_gid",   32'(grant_id),     32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(pk5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
            check("rst_post_out", 32'(from_arbiter), 32'h00);
        end

        // randomized traffic, light then heavy load
        for (int n = 0; n < 1500; n++) begin
            rate = (n < 750) ? 15 : 50;
            for (int i = 0; i < REN; i++) begin
                rpk[i]    = PL'($urandom);
                rpk[i][0] = ($urandom_range(0, 99) < rate);
            end
            cycle(rpk, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
